// File: rtl/fft_spectrum_peak.sv
// Power stream and per-frame peak search on the pipeline FFT output.
// Malformed frames raise o_frame_err and never produce a peak report.
module fft_spectrum_peak #(
  parameter int LOGS_FFT_LEN  = 13,
  parameter int DATA_WIDTH    = 10,
  parameter int SKIP_DC       = 1,
  parameter int HALF_SPECTRUM = 1
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  input  logic                        i_axi4s_data_tvalid,
  input  logic [31:0]                 i_axi4s_data_tdata,
  input  logic                        i_axi4s_data_tlast,
  input  logic [23:0]                 i_axi4s_data_tuser,
  output logic                        o_pwr_tvalid,
  output logic [2*DATA_WIDTH-1:0]     o_pwr_tdata,
  output logic [LOGS_FFT_LEN-1:0]     o_pwr_tindex,
  output logic                        o_pwr_tlast,
  output logic                        o_peak_vld,
  output logic [LOGS_FFT_LEN-1:0]     o_peak_index,
  output logic [2*DATA_WIDTH-1:0]     o_peak_pwr,
  output logic [4:0]                  o_peak_blk_exp,
  output logic                        o_frame_err,
  output logic [15:0]                 o_frame_cnt
);

  localparam int L  = LOGS_FFT_LEN;
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [L-1:0] IDX_LAST = '1;
  localparam logic [L-1:0] WIN_LO =
    (SKIP_DC != 0) ? L'(1) : L'(0);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_nxt_state;
  logic [L-1:0] r_exp_idx;
  logic [L-1:0] w_nxt_exp;

  logic [L-1:0]         w_idx;
  logic [4:0]           w_bexp;
  logic signed [DW-1:0] w_re;
  logic signed [DW-1:0] w_im;
  logic signed [PW-1:0] w_re_x;
  logic signed [PW-1:0] w_im_x;
  logic [PW-1:0]        w_re_sq;
  logic [PW-1:0]        w_im_sq;
  logic                 w_unused;

  assign w_idx  = i_axi4s_data_tuser[L-1:0];
  assign w_bexp = i_axi4s_data_tuser[20:16];
  assign w_re   = i_axi4s_data_tdata[DW-1:0];
  assign w_im   = i_axi4s_data_tdata[16+DW-1:16];
  assign w_re_x = {{DW{w_re[DW-1]}}, w_re};
  assign w_im_x = {{DW{w_im[DW-1]}}, w_im};
  assign w_re_sq = w_re_x * w_re_x;
  assign w_im_sq = w_im_x * w_im_x;
  assign w_unused = ^{i_axi4s_data_tdata[15:DW],
                      i_axi4s_data_tdata[31:16+DW],
                      i_axi4s_data_tuser[23:21],
                      i_axi4s_data_tuser[15:L]};

  logic w_seq_ok;
  logic w_end_ok;
  logic w_restart;

  assign w_seq_ok  = (w_idx == r_exp_idx) &&
                     !i_axi4s_data_tlast &&
                     (w_idx != IDX_LAST);
  assign w_end_ok  = (w_idx == IDX_LAST) &&
                     i_axi4s_data_tlast &&
                     (r_exp_idx == IDX_LAST);
  assign w_restart = (w_idx == '0) &&
                     !i_axi4s_data_tlast;

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state   <= S_IDLE;
      r_exp_idx <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_exp_idx <= w_nxt_exp;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_exp   = r_exp_idx;
    if (i_axi4s_data_tvalid) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_idx == '0) begin
            w_nxt_state = S_ACTIVE;
            w_nxt_exp   = L'(1);
          end
        end
        S_ACTIVE: begin
          if (w_seq_ok) begin
            w_nxt_exp = r_exp_idx + L'(1);
          end else if (w_end_ok) begin
            w_nxt_state = S_IDLE;
          end else if (w_restart) begin
            w_nxt_exp = L'(1);
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  logic w_start;
  logic w_keep;
  logic w_clean;
  logic w_err;

  always_comb begin
    w_start = 1'b0;
    w_keep  = 1'b0;
    w_clean = 1'b0;
    w_err   = 1'b0;
    if (i_axi4s_data_tvalid) begin
      unique case (r_state)
        S_IDLE: begin
          w_start = (w_idx == '0);
          w_keep  = w_start;
        end
        S_ACTIVE: begin
          w_clean = w_end_ok;
          w_err   = !w_seq_ok && !w_end_ok;
          w_start = w_err && w_restart;
          w_keep  = w_seq_ok || w_end_ok || w_start;
        end
        default: ;
      endcase
    end
  end

  logic          r_s1_vld;
  logic [PW-1:0] r_s1_re_sq;
  logic [PW-1:0] r_s1_im_sq;
  logic [L-1:0]  r_s1_idx;
  logic          r_s1_last;
  logic          r_s1_keep;
  logic          r_s1_start;
  logic          r_s1_clean;
  logic [4:0]    r_s1_bexp;
  logic          r_s2_keep;
  logic          r_s2_start;
  logic          r_s2_clean;
  logic [4:0]    r_s2_bexp;
  logic [L-1:0]  r_run_idx;
  logic [PW-1:0] r_run_pwr;
  logic [4:0]    r_run_exp;

  // A frame-start beat searches against a fresh baseline, not the old peak.
  logic [L-1:0]  w_base_idx;
  logic [PW-1:0] w_base_pwr;
  logic          w_in_win;
  logic          w_upd;
  logic [L-1:0]  w_nxt_idx;
  logic [PW-1:0] w_nxt_pwr;

  assign w_base_idx = r_s2_start ? WIN_LO : r_run_idx;
  assign w_base_pwr = r_s2_start ? '0 : r_run_pwr;
  assign w_in_win =
    ((SKIP_DC == 0) || (o_pwr_tindex != '0)) &&
    ((HALF_SPECTRUM == 0) || !o_pwr_tindex[L-1]);
  assign w_upd = w_in_win && (o_pwr_tdata > w_base_pwr);
  assign w_nxt_idx = w_upd ? o_pwr_tindex : w_base_idx;
  assign w_nxt_pwr = w_upd ? o_pwr_tdata : w_base_pwr;

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_s1_vld       <= 1'b0;
      r_s1_re_sq     <= '0;
      r_s1_im_sq     <= '0;
      r_s1_idx       <= '0;
      r_s1_last      <= 1'b0;
      r_s1_keep      <= 1'b0;
      r_s1_start     <= 1'b0;
      r_s1_clean     <= 1'b0;
      r_s1_bexp      <= '0;
      o_pwr_tvalid   <= 1'b0;
      o_pwr_tdata    <= '0;
      o_pwr_tindex   <= '0;
      o_pwr_tlast    <= 1'b0;
      r_s2_keep      <= 1'b0;
      r_s2_start     <= 1'b0;
      r_s2_clean     <= 1'b0;
      r_s2_bexp      <= '0;
      r_run_idx      <= '0;
      r_run_pwr      <= '0;
      r_run_exp      <= '0;
      o_peak_vld     <= 1'b0;
      o_peak_index   <= '0;
      o_peak_pwr     <= '0;
      o_peak_blk_exp <= '0;
      o_frame_err    <= 1'b0;
      o_frame_cnt    <= '0;
    end else begin
      r_s1_vld   <= i_axi4s_data_tvalid;
      r_s1_keep  <= w_keep;
      r_s1_start <= w_start;
      r_s1_clean <= w_clean;
      if (i_axi4s_data_tvalid) begin
        r_s1_re_sq <= w_re_sq;
        r_s1_im_sq <= w_im_sq;
        r_s1_idx   <= w_idx;
        r_s1_last  <= i_axi4s_data_tlast;
        r_s1_bexp  <= w_bexp;
      end
      o_pwr_tvalid <= r_s1_vld;
      r_s2_keep    <= r_s1_vld && r_s1_keep;
      r_s2_start   <= r_s1_vld && r_s1_start;
      r_s2_clean   <= r_s1_vld && r_s1_clean;
      if (r_s1_vld) begin
        o_pwr_tdata  <= r_s1_re_sq + r_s1_im_sq;
        o_pwr_tindex <= r_s1_idx;
        o_pwr_tlast  <= r_s1_last;
        r_s2_bexp    <= r_s1_bexp;
      end
      o_frame_err <= w_err;
      o_peak_vld  <= 1'b0;
      if (o_pwr_tvalid && r_s2_keep) begin
        r_run_idx <= w_nxt_idx;
        r_run_pwr <= w_nxt_pwr;
        if (r_s2_start) begin
          r_run_exp <= r_s2_bexp;
        end
      end
      if (o_pwr_tvalid && r_s2_clean) begin
        o_peak_vld     <= 1'b1;
        o_peak_index   <= w_nxt_idx;
        o_peak_pwr     <= w_nxt_pwr;
        o_peak_blk_exp <= r_run_exp;
        o_frame_cnt    <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_spectrum_peak.sv
// Bench for fft_spectrum_peak: directed frames plus random spectra,
// checked against a frame-level reference model.
module tb_fft_spectrum_peak;

  localparam int L = 13;
  localparam int N = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic [23:0] tuser = '0;

  logic          o_pwr_tvalid;
  logic [19:0]   o_pwr_tdata;
  logic [L-1:0]  o_pwr_tindex;
  logic          o_pwr_tlast;
  logic          o_peak_vld;
  logic [L-1:0]  o_peak_index;
  logic [19:0]   o_peak_pwr;
  logic [4:0]    o_peak_blk_exp;
  logic          o_frame_err;
  logic [15:0]   o_frame_cnt;

  always #5 clk = ~clk;

  fft_spectrum_peak dut (
    .i_aclk              (clk),
    .i_areset            (rst),
    .i_axi4s_data_tvalid (tvalid),
    .i_axi4s_data_tdata  (tdata),
    .i_axi4s_data_tlast  (tlast),
    .i_axi4s_data_tuser  (tuser),
    .o_pwr_tvalid        (o_pwr_tvalid),
    .o_pwr_tdata         (o_pwr_tdata),
    .o_pwr_tindex        (o_pwr_tindex),
    .o_pwr_tlast         (o_pwr_tlast),
    .o_peak_vld          (o_peak_vld),
    .o_peak_index        (o_peak_index),
    .o_peak_pwr          (o_peak_pwr),
    .o_peak_blk_exp      (o_peak_blk_exp),
    .o_frame_err         (o_frame_err),
    .o_frame_cnt         (o_frame_cnt)
  );

  typedef struct {
    int cyc;
    int pwr;
    int idx;
    int last;
  } pwr_t;

  typedef struct {
    int cyc;
    int idx;
    int pwr;
    int bexp;
    int cnt;
  } pk_t;

  pwr_t pwr_q[$];
  pk_t  pk_q[$];
  int   err_q[$];
  int   pk_obs[$];
  int   exp_cnt = 0;
  int   fr_re[N];
  int   fr_im[N];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    pwr_t e;
    pk_t  p;
    if (!rst) begin
      if (o_pwr_tvalid === 1'b1) begin
        if (pwr_q.size() == 0) begin
          chk("pwr_unexpected", 1, 0);
        end else begin
          e = pwr_q.pop_front();
          chk("pwr_cycle", cyc, e.cyc);
          chk("pwr_data", o_pwr_tdata, e.pwr);
          chk("pwr_index", o_pwr_tindex, e.idx);
          chk("pwr_last", o_pwr_tlast, e.last);
        end
      end
      if (o_peak_vld === 1'b1) begin
        pk_obs.push_back(cyc);
        if (pk_q.size() == 0) begin
          chk("peak_unexpected", 1, 0);
        end else begin
          p = pk_q.pop_front();
          chk("peak_cycle", cyc, p.cyc);
          chk("peak_index", o_peak_index, p.idx);
          chk("peak_pwr", o_peak_pwr, p.pwr);
          chk("peak_exp", o_peak_blk_exp, p.bexp);
          chk("peak_cnt", o_frame_cnt, p.cnt);
        end
      end
      if (o_frame_err === 1'b1) begin
        if (err_q.size() == 0) begin
          chk("err_unexpected", 1, 0);
        end else begin
          chk("err_cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  task automatic beat(input int idx, input bit last,
                      input int bexp, output int dcyc);
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = {16'(fr_im[idx]), 16'(fr_re[idx])};
    tlast  = last;
    tuser  = {3'b0, 5'(bexp), 3'b0, 13'(idx)};
    dcyc   = cyc;
    pwr_q.push_back('{cyc + 2,
                      fr_re[idx] * fr_re[idx] + fr_im[idx] * fr_im[idx],
                      idx, int'(last)});
  endtask

  task automatic gap();
    @(negedge clk);
    tvalid = 1'b0;
    tdata  = $urandom;
    tlast  = 1'($urandom);
    tuser  = 24'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) gap();
  endtask

  task automatic clear_fr();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic rand_fr();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = int'($urandom_range(0, 1023)) - 512;
      fr_im[i] = int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  // Reference peak: bins 1..N/2-1, first strictly larger power wins.
  task automatic push_peak(input int dcyc, input int bexp);
    int bi;
    int bp;
    int p;
    bi = 1;
    bp = 0;
    for (int i = 1; i < N / 2; i++) begin
      p = fr_re[i] * fr_re[i] + fr_im[i] * fr_im[i];
      if (p > bp) begin
        bp = p;
        bi = i;
      end
    end
    exp_cnt++;
    pk_q.push_back('{dcyc + 3, bi, bp, bexp, exp_cnt & 16'hFFFF});
  endtask

  task automatic send_frame(input int lo, input int hi,
                            input int last_idx, input int bexp,
                            input int gap_pct, input bit clean,
                            output int dlast);
    int dc;
    dc = 0;
    for (int i = lo; i <= hi; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) gap();
      beat(i, i == last_idx, bexp, dc);
    end
    dlast = dc;
    if (clean) push_peak(dc, bexp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pwr_vld"}, o_pwr_tvalid, 0);
    chk({tag, "_pwr_data"}, o_pwr_tdata, 0);
    chk({tag, "_pwr_idx"}, o_pwr_tindex, 0);
    chk({tag, "_pwr_last"}, o_pwr_tlast, 0);
    chk({tag, "_pk_vld"}, o_peak_vld, 0);
    chk({tag, "_pk_idx"}, o_peak_index, 0);
    chk({tag, "_pk_pwr"}, o_peak_pwr, 0);
    chk({tag, "_pk_exp"}, o_peak_blk_exp, 0);
    chk({tag, "_err"}, o_frame_err, 0);
    chk({tag, "_cnt"}, o_frame_cnt, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst    = 1'b1;
    tvalid = 1'b0;
    repeat (3) @(negedge clk);
    pwr_q.delete();
    pk_q.delete();
    err_q.delete();
    exp_cnt = 0;
    check_zero(tag);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int dc;
    int np;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    clear_fr();
    fr_re[100] = 300;
    fr_im[100] = -400;
    send_frame(0, N - 1, N - 1, 5, 0, 1, dc);
    idle(6);
    chk("single_idx", o_peak_index, 100);
    chk("single_pwr", o_peak_pwr, 250000);
    chk("single_exp", o_peak_blk_exp, 5);
    chk("single_cnt", o_frame_cnt, 1);

    clear_fr();
    fr_re[20] = 100;
    fr_re[30] = 100;
    send_frame(0, N - 1, N - 1, 9, 0, 1, dc);
    idle(6);
    chk("tie_idx", o_peak_index, 20);
    chk("tie_pwr", o_peak_pwr, 10000);

    clear_fr();
    fr_re[0] = -512;
    fr_im[0] = -512;
    fr_re[5000] = 511;
    fr_re[7] = 10;
    send_frame(0, N - 1, N - 1, 17, 0, 1, dc);
    idle(6);
    chk("dc_idx", o_peak_index, 7);
    chk("dc_pwr", o_peak_pwr, 100);
    chk("dc_cnt", o_frame_cnt, 3);

    rand_fr();
    send_frame(0, 49, -1, 3, 0, 0, dc);
    beat(51, 0, 3, dc);
    err_q.push_back(dc + 1);
    idle(6);
    chk("skip_cnt", o_frame_cnt, 3);

    send_frame(0, 4095, 4095, 4, 0, 0, dc);
    err_q.push_back(dc + 1);
    idle(6);
    chk("early_cnt", o_frame_cnt, 3);

    rand_fr();
    send_frame(0, N - 1, N - 1, int'($urandom_range(0, 31)),
               10, 1, dc);
    idle(6);
    chk("rand_cnt", o_frame_cnt, 4);

    rand_fr();
    send_frame(0, N - 1, N - 1, int'($urandom_range(0, 31)),
               0, 1, dc);
    rand_fr();
    send_frame(0, N - 1, N - 1, int'($urandom_range(0, 31)),
               0, 1, dc);
    rand_fr();
    send_frame(0, 999, -1, 11, 0, 0, dc);
    np = pk_obs.size();
    chk("b2b_npeaks", np, 6);
    if (np >= 2) chk("b2b_gap", pk_obs[np - 1] - pk_obs[np - 2], N);
    do_reset("midreset");
    idle(20);
    chk("midreset_npeaks", pk_obs.size(), 6);

    rand_fr();
    beat(3, 0, 2, dc);
    beat(4, 0, 2, dc);
    send_frame(0, N - 1, N - 1, 21, 5, 1, dc);
    idle(8);
    chk("post_cnt", o_frame_cnt, 1);
    chk("post_exp", o_peak_blk_exp, 21);

    chk("pwr_left", pwr_q.size(), 0);
    chk("peak_left", pk_q.size(), 0);
    chk("err_left", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_spectrum_peak.md
# fft_spectrum_peak

Downstream consumer of the 8192-point pipeline FFT output stream. Converts each complex bin to power (re² + im²) on a 2-cycle pipeline and re-emits it as a power stream. It also searches every clean frame for its maximum-power bin, reporting the index, power and block exponent once per frame. Frame integrity is checked against the FFT output index; malformed frames are flagged and excluded from peak reporting.

## Interface
Parameters:
- LOGS_FFT_LEN, 13, log2 of FFT length N
- DATA_WIDTH, 10, signed width of re/im inside each 16-bit tdata half
- SKIP_DC, 1, 1 = bin 0 excluded from peak search
- HALF_SPECTRUM, 1, 1 = search bins up to N/2-1 only; 0 = up to N-1

Ports:
- i_aclk  in  1  single clock
- i_areset  in  1  reset, synchronous, active-high
- i_axi4s_data_tvalid  in  1  FFT output beat valid (no backpressure, no tready)
- i_axi4s_data_tdata  in  32  [DATA_WIDTH-1:0] re, [16+DATA_WIDTH-1:16] im, two's complement
- i_axi4s_data_tlast  in  1  last bin of frame
- i_axi4s_data_tuser  in  24  [LOGS_FFT_LEN-1:0] bin index, [20:16] block exponent
- o_pwr_tvalid  out  1  power beat valid
- o_pwr_tdata  out  2*DATA_WIDTH  unsigned re²+im²
- o_pwr_tindex  out  LOGS_FFT_LEN  bin index of power beat
- o_pwr_tlast  out  1  delayed tlast
- o_peak_vld  out  1  one-cycle pulse, peak result valid
- o_peak_index  out  LOGS_FFT_LEN  index of max bin, held until next pulse
- o_peak_pwr  out  2*DATA_WIDTH  power of max bin, held
- o_peak_blk_exp  out  5  block exponent of that frame, held
- o_frame_err  out  1  one-cycle pulse on frame structure error
- o_frame_cnt  out  16  count of clean frames reported, wraps FFFF→0

## Operation
- Power path, applied to every valid beat regardless of frame state: stage 1 registers re² and im² (signed × signed, each ≤ 2^(2·DATA_WIDTH-2)); stage 2 registers sum, unsigned, 2·DATA_WIDTH bits, never overflows (max 2^19 at DATA_WIDTH=10). Index and tlast delayed alongside.
- Frame FSM, states IDLE and ACTIVE, with expected-index counter exp_idx:
  - IDLE: valid beat with index 0 → ACTIVE; capture blk_exp; clear running peak; exp_idx = 1. Any other valid beat is ignored silently.
  - ACTIVE: valid beat with index == exp_idx and no tlast → exp_idx++.
  - ACTIVE: valid beat with index == N-1 and tlast → frame clean; schedule peak report; → IDLE.
  - ACTIVE error conditions: index != exp_idx; tlast with index != N-1; index N-1 without tlast. Any of these → o_frame_err pulse, no peak report, → IDLE. If the offending beat has index 0 and no tlast, it instead restarts the frame (→ ACTIVE with exp_idx = 1) in the same cycle, and the error pulse is still issued.
- Peak search runs on stage-2 outputs belonging to the active frame, within the window [SKIP_DC, HALF_SPECTRUM ? N/2-1 : N-1].
  - Update only on strictly greater power, so ties keep the lowest index.
  - A window of all-zero power reports index = window start, power 0.
- Report: o_peak_index, o_peak_pwr, o_peak_blk_exp load from running peak; o_peak_vld pulses; o_frame_cnt increments.
- Running peak and report registers are separate, so back-to-back frames (index 0 on the cycle after tlast) are supported.

## Timing
- Reset: all outputs 0, FSM IDLE, exp_idx 0, pipeline valids cleared.
- Reset mid-frame: partial frame discarded, no peak or error pulse; first beat after reset must carry index 0.
- Power latency: beat accepted at cycle T → o_pwr_* valid at T+2, for every input beat. Gaps in tvalid propagate as gaps.
- Peak report: tlast beat at T → o_peak_vld and updated held values at T+3.
- Error: offending beat at T → o_frame_err at T+1. A scheduled peak for that frame is cancelled; no report for that frame is ever issued.
- Simultaneous report pulse and new-frame start are independent; no cycle is lost.

## Test plan
- Clean frame, all bins 0 except bin 100 = (re 300, im -400) → o_pwr_tdata 250000 at index 100, T+2; o_peak_vld at tlast+3 with index 100, pwr 250000, blk_exp as driven; o_frame_cnt 1.
- Tie: bins 20 and 30 both (re 100, im 0) → o_peak_index 20, o_peak_pwr 10000.
- DC/half-spectrum: bin 0 = (-512, -512), bin 5000 = (511, 0), bin 7 = (10, 0), defaults → peak index 7, pwr 100; DC and bin 5000 excluded.
- Index skip: indices 0..49 then 51 → o_frame_err pulse one cycle after index 51, no o_peak_vld for that frame, o_frame_cnt unchanged.
- Early tlast at index 4095 → o_frame_err pulse; next clean frame reports normally.
- Back-to-back two clean frames with tvalid held high, then i_areset asserted mid-third frame → two peak pulses 8192 cycles apart; after reset all outputs 0, and no pulse for the third frame.
